// File: rtl/global_pkg.sv
// global_pkg: shared types and RV32I load/store size codes for the load/store unit.
package global_pkg;
   typedef enum logic [1:0] {MEM_NONE, LOAD_DATA, STORE_DATA} memory_operation_t;
   typedef enum logic [1:0] {IDLE, BUS, RESP} lsu_state_t;
   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;
endpackage

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: byte-lane select, store replication and load extract/extend.
module lsu_lane_align (
   input  logic [2:0]  funct3,
   input  logic [1:0]  ofs,
   input  logic [31:0] store_data,
   input  logic [31:0] bus_data,
   output logic [3:0]  sel,
   output logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        misaligned
);
   logic        is_b, is_h;
   logic [31:0] sh;
   always_comb begin
      is_b       = funct3[1:0] == 2'b00;
      is_h       = funct3[1:0] == 2'b01;
      sel        = is_b ? 4'b0001 << ofs : is_h ? 4'b0011 << {ofs[1], 1'b0} : 4'b1111;
      wdata      = is_b ? {4{store_data[7:0]}} : is_h ? {2{store_data[15:0]}} : store_data;
      sh         = bus_data >> {(is_b ? ofs : {ofs[1], 1'b0}), 3'b000};
      // funct3[2] marks the unsigned variants
      rdata      = is_b ? {{24{sh[7] & ~funct3[2]}}, sh[7:0]}
                 : is_h ? {{16{sh[15] & ~funct3[2]}}, sh[15:0]} : bus_data;
      misaligned = is_h ? ofs[0] : !is_b && |ofs;
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one load/store command -> one Wishbone classic cycle with lane formatting.
// LSU_MISALIGN_TRAP_EN: misaligned accesses skip the bus and pulse misaligned instead.
module load_store_unit
   import global_pkg::*;
#(
   parameter int BUS_TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cyc,
   input  memory_operation_t memory_operation,
   input  logic [2:0]        funct3,
   input  logic [31:0]       address,
   input  logic [31:0]       store_data,
   output logic              ack,
   output logic              data_valid,
   output logic [31:0]       load_data,
   output logic              bus_error,
   output logic              misaligned,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [31:0]       wb_adr_o,
   output logic [31:0]       wb_dat_o,
   output logic [3:0]        wb_sel_o,
   input  logic [31:0]       wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i
);
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif
   lsu_state_t        state, state_nxt;
   memory_operation_t op;
   logic [31:0]       adr, sdat, wdata, rdata, load_data_nxt;
   logic [2:0]        f3;
   logic [3:0]        sel;
   logic              mis, trap, tmo, fail, done, err_q, err_nxt;
   logic              ack_nxt, dv_nxt, berr_nxt, mis_nxt;

   lsu_lane_align u_align (
      .funct3(f3), .ofs(adr[1:0]), .store_data(sdat), .bus_data(wb_dat_i),
      .sel(sel), .wdata(wdata), .rdata(rdata), .misaligned(mis)
   );

   // a trapped access parks in BUS for one cycle without driving the bus
   assign trap     = TRAP_EN && mis;
   assign wb_cyc_o = state == BUS && !trap;
   assign wb_stb_o = wb_cyc_o;
   assign wb_we_o  = wb_cyc_o && op == STORE_DATA;
   assign wb_adr_o = wb_cyc_o ? {adr[31:2], 2'b00} : '0;
   assign wb_sel_o = wb_cyc_o ? sel : '0;
   assign wb_dat_o = wb_cyc_o ? wdata : '0;

   generate
      if (BUS_TIMEOUT > 0) begin : g_tmo
         localparam int CW = $clog2(BUS_TIMEOUT + 1);
         logic [CW-1:0] cnt;
         always_ff @(posedge clk or posedge rst)
            if (rst) cnt <= '0;
            else     cnt <= wb_cyc_o ? cnt + 1'b1 : '0;
         assign tmo = wb_cyc_o && cnt == CW'(BUS_TIMEOUT - 1);
      end else begin : g_no_tmo
         assign tmo = 1'b0;
      end
   endgenerate

   always_comb begin
      state_nxt     = state;
      ack_nxt       = 1'b0;
      dv_nxt        = 1'b0;
      berr_nxt      = 1'b0;
      mis_nxt       = 1'b0;
      err_nxt       = err_q;
      load_data_nxt = load_data;
      fail          = wb_cyc_o && (wb_err_i || tmo);
      done          = trap || wb_ack_i || fail;
      case (state)
         IDLE: if (cyc && memory_operation != MEM_NONE) begin
            state_nxt = BUS;
            ack_nxt   = memory_operation == LOAD_DATA;
         end
         BUS: if (done) begin
            if (op == STORE_DATA) begin
               state_nxt = IDLE;
               ack_nxt   = 1'b1;
               berr_nxt  = fail;
               mis_nxt   = trap;
            end else begin
               state_nxt     = RESP;
               err_nxt       = fail;
               load_data_nxt = fail || trap ? '0 : rdata;
            end
         end
         RESP: begin
            state_nxt = IDLE;
            dv_nxt    = 1'b1;
            berr_nxt  = err_q;
            mis_nxt   = trap;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         op         <= MEM_NONE;
         adr        <= '0;
         f3         <= '0;
         sdat       <= '0;
         err_q      <= 1'b0;
         ack        <= 1'b0;
         data_valid <= 1'b0;
         bus_error  <= 1'b0;
         misaligned <= 1'b0;
         load_data  <= '0;
      end else begin
         state      <= state_nxt;
         err_q      <= err_nxt;
         ack        <= ack_nxt;
         data_valid <= dv_nxt;
         bus_error  <= berr_nxt;
         misaligned <= mis_nxt;
         load_data  <= load_data_nxt;
         if (state == IDLE && cyc && memory_operation != MEM_NONE) begin
            op   <= memory_operation;
            adr  <= address;
            f3   <= funct3;
            sdat <= store_data;
         end
      end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit, including a BUS_TIMEOUT=4 instance.
module tb_load_store_unit;
   import global_pkg::*;
   logic clk = 1'b0, rst = 1'b1, cyc = 1'b0, cyc_t = 1'b0, use_t = 1'b0;
   memory_operation_t memory_operation = MEM_NONE;
   logic [2:0]  funct3 = '0;
   logic [31:0] address = '0, store_data = '0, wb_dat_i = '0;
   logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
   logic        ack, data_valid, bus_error, misaligned, wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] load_data, wb_adr_o, wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        ack_t, dv_t, berr_t, mis_t, cyc_o_t, stb_o_t, we_o_t;
   logic [31:0] ld_t, adr_o_t, dat_o_t;
   logic [3:0]  sel_o_t;
   logic        o_ack, o_dv, o_berr, o_mis, o_cyc, o_we;
   logic [31:0] o_ld, o_adr, o_dat;
   logic [3:0]  o_sel;
   int total = 0, bad = 0;
   int n_ack, n_dv, n_cyc, n_berr, n_mis, ack_at, dv_at, berr_at, mis_at;
   logic [31:0] dv_data, s_adr, s_dat;
   logic [3:0]  s_sel;
   logic        s_we;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst), .cyc(cyc), .memory_operation(memory_operation), .funct3(funct3),
      .address(address), .store_data(store_data), .ack(ack), .data_valid(data_valid),
      .load_data(load_data), .bus_error(bus_error), .misaligned(misaligned),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
      .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i)
   );

   load_store_unit #(.BUS_TIMEOUT(4)) dut_t (
      .clk(clk), .rst(rst), .cyc(cyc_t), .memory_operation(memory_operation), .funct3(funct3),
      .address(address), .store_data(store_data), .ack(ack_t), .data_valid(dv_t),
      .load_data(ld_t), .bus_error(berr_t), .misaligned(mis_t),
      .wb_cyc_o(cyc_o_t), .wb_stb_o(stb_o_t), .wb_we_o(we_o_t), .wb_adr_o(adr_o_t),
      .wb_dat_o(dat_o_t), .wb_sel_o(sel_o_t), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i)
   );

   assign o_ack  = use_t ? ack_t   : ack;
   assign o_dv   = use_t ? dv_t    : data_valid;
   assign o_berr = use_t ? berr_t  : bus_error;
   assign o_mis  = use_t ? mis_t   : misaligned;
   assign o_cyc  = use_t ? cyc_o_t : wb_cyc_o;
   assign o_we   = use_t ? we_o_t  : wb_we_o;
   assign o_ld   = use_t ? ld_t    : load_data;
   assign o_adr  = use_t ? adr_o_t : wb_adr_o;
   assign o_dat  = use_t ? dat_o_t : wb_dat_o;
   assign o_sel  = use_t ? sel_o_t : wb_sel_o;

   // issues one command, plays a slave with `waits` wait states and records what was observed
   task automatic run(input memory_operation_t op_i, input logic [2:0] f3_i, input logic [31:0] a_i,
                      input logic [31:0] sd_i, input int waits, input logic [31:0] rd_i,
                      input bit err_i, input bit hold);
      logic c;
      @(posedge clk); #1;
      cyc = !use_t; cyc_t = use_t; memory_operation = op_i;
      funct3 = f3_i; address = a_i; store_data = sd_i; wb_dat_i = rd_i;
      n_ack = 0; n_dv = 0; n_cyc = 0; n_berr = 0; n_mis = 0;
      ack_at = -1; dv_at = -1; berr_at = -1; mis_at = -1; dv_data = 'x;
      s_adr = 'x; s_dat = 'x; s_sel = 'x; s_we = 1'bx;
      for (int t = 1; t <= 20; t++) begin
         @(posedge clk); #1;
         if (o_ack)  begin n_ack++;  if (ack_at < 0) ack_at = t; end
         if (o_dv)   begin n_dv++;   dv_at = t; dv_data = o_ld; end
         if (o_berr) begin n_berr++; berr_at = t; end
         if (o_mis)  begin n_mis++;  mis_at = t; end
         if (o_cyc) begin
            if (n_cyc == 0) begin s_adr = o_adr; s_dat = o_dat; s_sel = o_sel; s_we = o_we; end
            n_cyc++;
         end
         c = hold && o_cyc;
         cyc = c && !use_t; cyc_t = c && use_t;
         memory_operation = c ? op_i : MEM_NONE;
         wb_ack_i = o_cyc && n_cyc > waits;
         wb_err_i = o_cyc && n_cyc > waits && err_i;
      end
   endtask

   task automatic test_reset;
      #1;
      total++; if ({ack, data_valid, bus_error, misaligned} !== 4'b0) begin bad++; $display("FAIL reset_pulses: got %b want 0000", {ack, data_valid, bus_error, misaligned}); end
      total++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b0) begin bad++; $display("FAIL reset_wb_ctl: got %b want 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
      total++; if (load_data !== 32'h0) begin bad++; $display("FAIL reset_load_data: got %h want 0", load_data); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_load;
      run(LOAD_DATA, LS_B, 32'h102, 32'h0, 0, 32'h12F03456, 1'b0, 1'b0);
      total++; if (ack_at !== 1 || n_ack !== 1) begin bad++; $display("FAIL lb_ack: at=%0d n=%0d want at=1 n=1", ack_at, n_ack); end
      total++; if (dv_at !== 3 || n_dv !== 1) begin bad++; $display("FAIL lb_dv: at=%0d n=%0d want at=3 n=1", dv_at, n_dv); end
      total++; if (dv_data !== 32'hFFFFFFF0) begin bad++; $display("FAIL lb_data: got %h want fffffff0", dv_data); end
      total++; if (s_sel !== 4'b0100 || s_adr !== 32'h100 || s_we !== 1'b0) begin bad++; $display("FAIL lb_bus: sel=%b adr=%h we=%b want 0100 100 0", s_sel, s_adr, s_we); end
      run(LOAD_DATA, LS_BU, 32'h102, 32'h0, 0, 32'h12F03456, 1'b0, 1'b0);
      total++; if (dv_data !== 32'h000000F0) begin bad++; $display("FAIL lbu_data: got %h want 000000f0", dv_data); end
      run(LOAD_DATA, LS_H, 32'h102, 32'h0, 3, 32'h80011234, 1'b0, 1'b1);
      total++; if (n_cyc !== 4) begin bad++; $display("FAIL lh_wait_cycles: got %0d want 4", n_cyc); end
      total++; if (dv_data !== 32'hFFFF8001 || dv_at !== 6) begin bad++; $display("FAIL lh_data: got %h at %0d want ffff8001 at 6", dv_data, dv_at); end
      total++; if (n_ack !== 1 || n_dv !== 1 || s_sel !== 4'b1100) begin bad++; $display("FAIL lh_cyc_ignored: acks=%0d dvs=%0d sel=%b want 1 1 1100", n_ack, n_dv, s_sel); end
      run(LOAD_DATA, LS_HU, 32'h100, 32'h0, 0, 32'h12F0F456, 1'b0, 1'b0);
      total++; if (dv_data !== 32'h0000F456) begin bad++; $display("FAIL lhu_data: got %h want 0000f456", dv_data); end
   endtask

   task automatic test_store;
      run(STORE_DATA, LS_W, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b0);
      total++; if (s_adr !== 32'h100 || s_sel !== 4'b1111 || s_we !== 1'b1 || s_dat !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_bus: adr=%h sel=%b we=%b dat=%h want 100 1111 1 deadbeef", s_adr, s_sel, s_we, s_dat); end
      total++; if (ack_at !== 2 || n_ack !== 1 || n_dv !== 0 || n_cyc !== 1) begin bad++; $display("FAIL sw_handshake: ack_at=%0d acks=%0d dvs=%0d cyc=%0d want 2 1 0 1", ack_at, n_ack, n_dv, n_cyc); end
      total++; if (load_data !== 32'h0000F456) begin bad++; $display("FAIL sw_load_data_held: got %h want 0000f456", load_data); end
      run(STORE_DATA, LS_B, 32'h103, 32'h000000A5, 0, 32'h0, 1'b0, 1'b0);
      total++; if (s_sel !== 4'b1000 || s_dat !== 32'hA5A5A5A5 || s_adr !== 32'h100) begin bad++; $display("FAIL sb_lanes: sel=%b dat=%h adr=%h want 1000 a5a5a5a5 100", s_sel, s_dat, s_adr); end
      run(STORE_DATA, LS_H, 32'h202, 32'h00001234, 0, 32'h0, 1'b0, 1'b0);
      total++; if (s_sel !== 4'b1100 || s_dat !== 32'h12341234 || s_adr !== 32'h200) begin bad++; $display("FAIL sh_lanes: sel=%b dat=%h adr=%h want 1100 12341234 200", s_sel, s_dat, s_adr); end
   endtask

   task automatic test_bus_error;
      run(LOAD_DATA, LS_W, 32'h104, 32'h0, 1, 32'h55555555, 1'b1, 1'b0);
      total++; if (dv_data !== 32'h0 || n_berr !== 1 || berr_at !== dv_at || dv_at !== 4) begin bad++; $display("FAIL lw_err: data=%h berr=%0d berr_at=%0d dv_at=%0d want 0 1 4 4", dv_data, n_berr, berr_at, dv_at); end
      run(STORE_DATA, LS_W, 32'h104, 32'h1, 0, 32'h0, 1'b1, 1'b0);
      total++; if (n_berr !== 1 || berr_at !== ack_at || ack_at !== 2) begin bad++; $display("FAIL sw_err: berr=%0d berr_at=%0d ack_at=%0d want 1 2 2", n_berr, berr_at, ack_at); end
   endtask

   task automatic test_misaligned;
`ifdef LSU_MISALIGN_TRAP_EN
      run(LOAD_DATA, LS_W, 32'h101, 32'h0, 0, 32'hCAFEF00D, 1'b0, 1'b0);
      total++; if (n_cyc !== 0) begin bad++; $display("FAIL lw_trap_nobus: cyc=%0d want 0", n_cyc); end
      total++; if (ack_at !== 1 || dv_at !== 3 || mis_at !== 3 || n_mis !== 1 || dv_data !== 32'h0) begin bad++; $display("FAIL lw_trap: ack_at=%0d dv_at=%0d mis_at=%0d n_mis=%0d data=%h want 1 3 3 1 0", ack_at, dv_at, mis_at, n_mis, dv_data); end
      run(STORE_DATA, LS_H, 32'h103, 32'h0, 0, 32'h0, 1'b0, 1'b0);
      total++; if (n_cyc !== 0 || ack_at !== 2 || mis_at !== 2 || n_mis !== 1) begin bad++; $display("FAIL sh_trap: cyc=%0d ack_at=%0d mis_at=%0d n_mis=%0d want 0 2 2 1", n_cyc, ack_at, mis_at, n_mis); end
`else
      run(LOAD_DATA, LS_W, 32'h101, 32'h0, 0, 32'hCAFEF00D, 1'b0, 1'b0);
      total++; if (s_adr !== 32'h100 || s_sel !== 4'b1111 || dv_data !== 32'hCAFEF00D) begin bad++; $display("FAIL lw_misaligned: adr=%h sel=%b data=%h want 100 1111 cafef00d", s_adr, s_sel, dv_data); end
      run(LOAD_DATA, LS_H, 32'h103, 32'h0, 0, 32'hCAFEF00D, 1'b0, 1'b0);
      total++; if (s_sel !== 4'b1100 || dv_data !== 32'hFFFFCAFE || n_mis !== 0) begin bad++; $display("FAIL lh_misaligned: sel=%b data=%h mis=%0d want 1100 ffffcafe 0", s_sel, dv_data, n_mis); end
`endif
   endtask

   task automatic test_back_to_back;
      int acks;
      acks = 0;
      @(posedge clk); #1;
      cyc = 1'b1; memory_operation = STORE_DATA; funct3 = LS_W; address = 32'h200; store_data = 32'h7;
      for (int t = 0; t < 10; t++) begin
         @(posedge clk); #1;
         acks += int'(ack);
         wb_ack_i = wb_cyc_o;
      end
      cyc = 1'b0; memory_operation = MEM_NONE; wb_ack_i = 1'b0;
      total++; if (acks !== 5) begin bad++; $display("FAIL back_to_back: acks=%0d want 5", acks); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_timeout;
      use_t = 1'b1;
      run(STORE_DATA, LS_W, 32'h300, 32'h1, 100, 32'h0, 1'b0, 1'b0);
      total++; if (n_cyc !== 4 || ack_at !== 5 || berr_at !== 5 || n_ack !== 1) begin bad++; $display("FAIL sw_timeout: cyc=%0d ack_at=%0d berr_at=%0d acks=%0d want 4 5 5 1", n_cyc, ack_at, berr_at, n_ack); end
      run(LOAD_DATA, LS_W, 32'h300, 32'h0, 100, 32'h12345678, 1'b0, 1'b0);
      total++; if (n_cyc !== 4 || dv_at !== 6 || berr_at !== 6 || dv_data !== 32'h0) begin bad++; $display("FAIL lw_timeout: cyc=%0d dv_at=%0d berr_at=%0d data=%h want 4 6 6 0", n_cyc, dv_at, berr_at, dv_data); end
      use_t = 1'b0;
   endtask

   task automatic test_async_reset;
      @(posedge clk); #1;
      cyc = 1'b1; memory_operation = LOAD_DATA; funct3 = LS_W; address = 32'h400;
      @(posedge clk); #1;
      cyc = 1'b0; memory_operation = MEM_NONE;
      total++; if (wb_cyc_o !== 1'b1) begin bad++; $display("FAIL rst_pre_bus: cyc=%b want 1", wb_cyc_o); end
      #1 rst = 1'b1;
      #1;
      total++; if ({wb_cyc_o, wb_stb_o, ack} !== 3'b000 || load_data !== 32'h0) begin bad++; $display("FAIL rst_async: cyc/stb/ack=%b load_data=%h want 000 0", {wb_cyc_o, wb_stb_o, ack}, load_data); end
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      test_reset;
      test_load;
      test_store;
      test_bus_error;
      test_misaligned;
      test_back_to_back;
      test_timeout;
      test_async_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
